sd_req_arbiter: RTL and testbench

- Shares the single hps_io SD block-transfer channel (sd_lba, sd_ack, sd_buff_*) between NUM_DRV virtual-disk clients (FDD0/FDD1 and two spare slots, matching VDNUM=4).
- Round-robin grant; per-client read/write requests; hps_io strobes and buffer writes steered to the granted client only.
- Sits in emu between hps_io and PC88MiSTer's disk-image logic, in the clk_sys domain.

---
 rtl/sd_arb_pkg.sv | 18 +
 rtl/sd_req_arbiter_rr_pick.sv | 31 +++
 rtl/sd_req_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sd_req_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sd_arb_pkg.sv
// Shared types for the SD block-channel arbiter.
//   arb_state_t : arbiter FSM states
//   arb_op_t    : latched transfer direction of the current owner
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } arb_op_t;

endpackage

// File: rtl/sd_req_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
//   req    : request vector, one bit per client
//   ptr    : index of the highest-priority client this round
//   winner : one-hot first set bit at or above ptr (wrapping), zero if none
//   valid  : at least one request is set
module rr_pick #(
    parameter int unsigned NUM_DRV = 4,
    parameter int unsigned PtrW    = 2
) (
    input  logic [NUM_DRV-1:0] req,
    input  logic [PtrW-1:0]    ptr,
    output logic [NUM_DRV-1:0] winner,
    output logic               valid
);

    int unsigned idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < NUM_DRV; i++) begin
            idx = (32'(ptr) + i) % NUM_DRV;
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_req_arbiter.sv
// Shares the hps_io SD block-transfer channel between NUM_DRV disk clients.
//   clk_sys, reset       : system clock, synchronous active-high reset
//   req_rd/req_wr/req_lba: per-client level requests and LBAs (32 bits each)
//   req_done/req_err     : one-cycle completion / timeout pulses per client
//   buff_wr              : sd_buff_wr steered to the owner during the transfer
//   grant                : one-hot owner while in REQ/XFER, zero otherwise
//   sd_lba/sd_rd/sd_wr   : request side towards hps_io
//   sd_ack/sd_buff_wr    : acknowledge and buffer strobe from hps_io
module sd_req_arbiter
    import sd_arb_pkg::*;
#(
    parameter int unsigned NUM_DRV = 4,
    parameter int unsigned TIMEOUT = 24'd12000000
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [NUM_DRV-1:0]    req_rd,
    input  logic [NUM_DRV-1:0]    req_wr,
    input  logic [32*NUM_DRV-1:0] req_lba,
    output logic [NUM_DRV-1:0]    req_done,
    output logic [NUM_DRV-1:0]    req_err,
    output logic [NUM_DRV-1:0]    buff_wr,
    output logic [NUM_DRV-1:0]    grant,
    output logic [31:0]           sd_lba,
    output logic [NUM_DRV-1:0]    sd_rd,
    output logic [NUM_DRV-1:0]    sd_wr,
    input  logic                  sd_ack,
    input  logic                  sd_buff_wr
);

    localparam int unsigned PtrW = (NUM_DRV > 1) ? $clog2(NUM_DRV) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

    arb_state_t         state_q, state_d;
    arb_op_t            op_q, op_d;
    logic [NUM_DRV-1:0] owner_q, owner_d;
    logic [PtrW-1:0]    idx_q, idx_d;
    logic [PtrW-1:0]    rr_q, rr_d;
    logic [31:0]        lba_q, lba_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [NUM_DRV-1:0] err_q, err_d;

    logic [NUM_DRV-1:0] winner;
    logic               win_valid;
    logic [PtrW-1:0]    win_idx;
    logic [31:0]        win_lba;
    logic [PtrW-1:0]    rr_next;

    rr_pick #(
        .NUM_DRV (NUM_DRV),
        .PtrW    (PtrW)
    ) u_rr_pick (
        .req    (req_rd | req_wr),
        .ptr    (rr_q),
        .winner (winner),
        .valid  (win_valid)
    );

    // Index and LBA of the one-hot winner.
    always_comb begin
        win_idx = '0;
        win_lba = '0;
        for (int unsigned i = 0; i < NUM_DRV; i++) begin
            if (winner[i]) begin
                win_idx = PtrW'(i);
                win_lba = req_lba[32*i +: 32];
            end
        end
    end

    assign rr_next = PtrW'((32'(idx_q) + 32'd1) % NUM_DRV);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        owner_d = owner_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        lba_d   = lba_q;
        cnt_d   = cnt_q;
        err_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    owner_d = winner;
                    idx_d   = win_idx;
                    lba_d   = win_lba;
                    // Write wins when a client raises both requests.
                    op_d    = (|(winner & req_wr)) ? OP_WR : OP_RD;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A stale ack already high on entry counts as a real ack.
                if (sd_ack) begin
                    state_d = XFER;
                end else if (!(|(owner_q & (req_rd | req_wr)))) begin
                    state_d = IDLE;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    err_d   = owner_q;
                    rr_d    = rr_next;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rr_d    = rr_next;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_RD;
            owner_q <= '0;
            idx_q   <= '0;
            rr_q    <= '0;
            lba_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            owner_q <= owner_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            lba_q   <= lba_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        grant    = '0;
        sd_rd    = '0;
        sd_wr    = '0;
        buff_wr  = '0;
        req_done = '0;
        if (state_q == REQ || state_q == XFER) begin
            grant = owner_q;
        end
        if (state_q == REQ) begin
            if (op_q == OP_WR) begin
                sd_wr = owner_q;
            end else begin
                sd_rd = owner_q;
            end
        end
        if (state_q == XFER && sd_buff_wr) begin
            buff_wr = owner_q;
        end
        if (state_q == DONE) begin
            req_done = owner_q;
        end
    end

    assign req_err = err_q;
    assign sd_lba  = lba_q;

endmodule

// File: tb/tb_sd_req_arbiter.sv
module tb_sd_req_arbiter;

    localparam int unsigned N = 4;

    logic            clk_sys = 1'b0;
    logic            reset;
    logic [N-1:0]    req_rd, req_wr;
    logic [32*N-1:0] req_lba;
    logic [N-1:0]    req_done, req_err, buff_wr, grant, sd_rd, sd_wr;
    logic [31:0]     sd_lba;
    logic            sd_ack, sd_buff_wr;

    int checks   = 0;
    int failures = 0;

    sd_req_arbiter #(
        .NUM_DRV (N),
        .TIMEOUT (16)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .req_rd     (req_rd),
        .req_wr     (req_wr),
        .req_lba    (req_lba),
        .req_done   (req_done),
        .req_err    (req_err),
        .buff_wr    (buff_wr),
        .grant      (grant),
        .sd_lba     (sd_lba),
        .sd_rd      (sd_rd),
        .sd_wr      (sd_wr),
        .sd_ack     (sd_ack),
        .sd_buff_wr (sd_buff_wr)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a grant, completes one transfer and checks owner and done.
    task automatic run_xfer(input string tag, input logic [N-1:0] exp_grant);
        for (int i = 0; i < 8 && grant == '0; i++) tick();
        chk({tag, " grant"}, 32'(grant), 32'(exp_grant));
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        tick();
        chk({tag, " done"}, 32'(req_done), 32'(exp_grant));
        tick();
    endtask

    int pulses;
    int stray;

    initial begin
        reset      = 1'b1;
        req_rd     = '0;
        req_wr     = '0;
        req_lba    = '0;
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        req_lba[31:0]   = 32'h0000_0010;
        req_lba[63:32]  = 32'h2222_0001;
        req_lba[95:64]  = 32'h3333_0002;
        req_lba[127:96] = 32'h4444_0003;
        tick();
        tick();
        chk("reset grant", 32'(grant), 0);
        chk("reset sd_rd", 32'(sd_rd), 0);
        chk("reset sd_lba", sd_lba, 0);
        chk("reset done/err", 32'({req_done, req_err}), 0);
        reset = 1'b0;
        tick();

        // Single read on client 0.
        req_rd = 4'b0001;
        tick();
        chk("rd strobe", 32'(sd_rd), 32'h1);
        chk("rd no wr", 32'(sd_wr), 0);
        chk("rd grant", 32'(grant), 32'h1);
        chk("rd lba", sd_lba, 32'h10);
        sd_buff_wr = 1'b1;
        #1;
        chk("buff_wr gated in REQ", 32'(buff_wr), 0);
        sd_buff_wr = 1'b0;
        sd_ack = 1'b1;
        tick();
        chk("rd strobe drop in XFER", 32'(sd_rd), 0);
        pulses = 0;
        stray  = 0;
        for (int i = 0; i < 19; i++) begin
            sd_buff_wr = (i == 2 || i == 5 || i == 8);
            #1;
            if (buff_wr == 4'b0001) pulses++;
            else if (buff_wr != '0) stray++;
            tick();
        end
        sd_buff_wr = 1'b0;
        chk("buff_wr pulses", pulses, 3);
        chk("buff_wr stray", stray, 0);
        chk("no early done", 32'(req_done), 0);
        sd_ack = 1'b0;
        tick();
        chk("rd done", 32'(req_done), 32'h1);
        chk("done grant", 32'(grant), 0);
        req_rd = '0;
        tick();
        chk("done one cycle", 32'(req_done), 0);

        // Contention from a fresh pointer.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_rd = 4'b0011;
        run_xfer("rr0", 4'b0001);
        run_xfer("rr1", 4'b0010);
        run_xfer("rr2", 4'b0001);
        run_xfer("rr3", 4'b0010);
        req_rd = '0;
        tick();

        // Read and write on one client: write wins.
        req_rd = 4'b0010;
        req_wr = 4'b0010;
        tick();
        chk("rdwr sd_wr", 32'(sd_wr), 32'h2);
        chk("rdwr sd_rd", 32'(sd_rd), 0);
        chk("rdwr lba", sd_lba, 32'h2222_0001);
        req_rd = '0;
        req_wr = '0;
        tick();

        // Abort before ack.
        req_wr = 4'b0100;
        tick();
        chk("abort strobe", 32'(sd_wr), 32'h4);
        chk("abort lba", sd_lba, 32'h3333_0002);
        req_wr = '0;
        tick();
        chk("abort strobes off", 32'({sd_rd, sd_wr}), 0);
        chk("abort grant", 32'(grant), 0);
        chk("abort no done/err", 32'({req_done, req_err}), 0);
        tick();
        chk("abort later done/err", 32'({req_done, req_err}), 0);
        chk("abort lba held", sd_lba, 32'h3333_0002);

        // Timeout, then next grant goes to client 1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_rd = 4'b0011;
        tick();
        chk("to strobe", 32'(sd_rd), 32'h1);
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (req_err != '0) stray++;
        end
        chk("to not early", stray, 0);
        tick();
        chk("to err", 32'(req_err), 32'h1);
        chk("to strobe off", 32'(sd_rd), 0);
        tick();
        chk("to err one cycle", 32'(req_err), 0);
        chk("to next grant", 32'(grant), 32'h2);
        req_rd = '0;
        tick();

        // Reset in the middle of a transfer.
        req_rd = 4'b0001;
        tick();
        sd_ack = 1'b1;
        tick();
        chk("mid grant", 32'(grant), 32'h1);
        reset = 1'b1;
        tick();
        chk("mid reset outs", 32'({grant, sd_rd, sd_wr, req_done, req_err}), 0);
        chk("mid reset lba", sd_lba, 0);
        reset  = 1'b0;
        req_rd = '0;
        sd_ack = 1'b0;
        tick();
        chk("mid no done", 32'(req_done), 0);
        tick();
        chk("mid no done later", 32'({req_done, grant}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
